brch_ckpt_fifo: RTL
===================

Name: brch_ckpt_fifo

Overview:
- Parametrised successor to the active-list branch FIFO: an in-order queue of branch checkpoints. Each entry is {rob index, recovery position}.
- Accepts up to WAYS branches per cycle from the allocate stage.
- Retires the head entry on a branch commit.
- On a mispredict, returns the mispredicted branch's recovery position to the freelist/map recovery logic and flushes that entry and all younger entries.

Parameters:
- DEPTH, 4: number of checkpoint entries. Power of two, DEPTH >= WAYS.
- WAYS, 4: instructions per allocate group (branch slots per cycle).
- IDX_W, 6: rob index width.
- POS_W, 7: recovery position width.

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst_n  input  1  reset, synchronous, active-low.
- brch  input  WAYS  per-way branch flag for the incoming group; way 0 is oldest.
- nxt_indx  input  IDX_W  rob index of way 0; way i index = nxt_indx + i, modulo 2^IDX_W.
- pos_in  input  WAYS*POS_W  per-way recovery position; way i occupies bits [i*POS_W +: POS_W].
- can_accept  output  1  combinational; 1 when free slots >= popcount(brch).
- cmt_brch  input  1  commit of the oldest outstanding branch.
- cmt_brch_indx  input  IDX_W  rob index of the committing branch.
- mis_pred  input  1  mispredict strobe.
- brch_mis_indx  input  IDX_W  rob index of the mispredicted branch.
- rcvr_vld  output  1  one-cycle pulse: rcvr_pos is valid.
- rcvr_pos  output  POS_W  recovery position of the mispredicted branch.
- mis_miss  output  1  one-cycle pulse: mispredict index not found.
- cmt_err  output  1  one-cycle pulse: commit while empty, or commit index differs from the head index.
- head_indx  output  IDX_W  index field of the head entry (0 when empty).
- count  output  clog2(DEPTH+1)  number of valid entries.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.

Behaviour:
- Storage: circular buffer with head and tail pointers. Each pointer has log2(DEPTH) bits plus a wrap bit. empty = pointers equal; full = low bits equal and wrap bits differ.
- Reset: when rst_n=0 at a posedge, head=tail=0 and all entries are invalid.
  - rcvr_vld=0, rcvr_pos=0, mis_miss=0, cmt_err=0, count=0, empty=1, full=0, head_indx=0.
  - Reset overrides every other input in that cycle, including mid-flush or mid-insert.
- Insert:
  - Applies when popcount(brch) > 0, can_accept=1, and no mispredict hit in the same cycle.
  - Flagged ways are compacted in way order into consecutive slots starting at tail.
  - tail advances by popcount(brch), wrapping modulo DEPTH.
  - When can_accept=0 the whole group is rejected; no partial insert. Upstream stalls and re-presents the group.
- Commit:
  - If cmt_brch=1, the buffer is non-empty, and head index == cmt_brch_indx: pop the head, head+1.
  - If the buffer is empty or the index mismatches: no state change, and cmt_err pulses on the next cycle.
- Mispredict:
  - Combinational search of valid entries for index == brch_mis_indx. On multiple matches, the oldest (nearest head) is taken.
  - Hit: tail <= slot of the match, so the match and every younger entry are removed. rcvr_pos <= that entry's pos, and rcvr_vld=1 on the next cycle only. Latency is 1 cycle.
  - Miss: no state change; mis_miss pulses next cycle; rcvr_pos holds its old value.
- Same-cycle priority:
  - The commit pop is evaluated first, then the mispredict search runs on the remaining entries. If both name the head, commit wins and the mispredict reports a miss.
  - A mispredict hit discards that cycle's insert group.
  - Commit plus insert in the same cycle: can_accept uses the pre-commit count, so a freed slot is not usable until the next cycle.
- count, empty, full, head_indx and can_accept are derived from the registered pointers and update one cycle after the event.
- Wrap-around: pointer and index arithmetic is modulo width. The rob index in nxt_indx + i may wrap from 63 to 0; entries store the wrapped value.

Test Plan:
- Reset, then a 4-branch insert: brch=1111, nxt_indx=10, pos 5/6/7/8 -> entries {10,5},{11,6},{12,7},{13,8}; count=4, full=1; next group brch=0001 gives can_accept=0 and count stays 4.
- Compaction: brch=1010, nxt_indx=62 -> entries {63,p1},{1,p3} (index wrap); count=2, head_indx=63.
- Mispredict hit: entries indices 20,21,22 at pos 30,31,32; mis_pred with index 21 -> next cycle rcvr_vld=1, rcvr_pos=31, count=1, head_indx=20.
- Faults:
  - Mispredict with index 40 not present -> mis_miss=1 for one cycle, count unchanged.
  - Commit on an empty buffer -> cmt_err=1.
  - Commit with index 7 while the head is 6 -> cmt_err=1, no pop.
- Simultaneous events: head 20, entries 20,21; cmt_brch idx 20 plus mis_pred idx 21 plus insert brch=0001 -> count=0, rcvr_pos = pos of 21, insert dropped.
- Wrap stress: 12 cycles of 1 insert plus 1 commit with DEPTH=4 -> pointers wrap three times, count stays 1, cmt_err never asserted. Assert rst_n=0 mid-stream -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/brch_ckpt_fifo.sv
// brch_ckpt_fifo: in-order branch checkpoint queue {rob index, recovery position} with multi-way insert, head commit and mispredict flush
module brch_ckpt_fifo #(
  parameter int DEPTH = 4,
  parameter int WAYS  = 4,
  parameter int IDX_W = 6,
  parameter int POS_W = 7
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WAYS-1:0]              brch,
  input  logic [IDX_W-1:0]             nxt_indx,
  input  logic [WAYS*POS_W-1:0]        pos_in,
  output logic                         can_accept,
  input  logic                         cmt_brch,
  input  logic [IDX_W-1:0]             cmt_brch_indx,
  input  logic                         mis_pred,
  input  logic [IDX_W-1:0]             brch_mis_indx,
  output logic                         rcvr_vld,
  output logic [POS_W-1:0]             rcvr_pos,
  output logic                         mis_miss,
  output logic                         cmt_err,
  output logic [IDX_W-1:0]             head_indx,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, cnt, pc, rem, hit_ptr, p, off;
  logic [IDX_W-1:0] idx_q [DEPTH];
  logic [IDX_W-1:0] idx_d [DEPTH];
  logic [POS_W-1:0] pos_q [DEPTH];
  logic [POS_W-1:0] pos_d [DEPTH];
  logic rcvr_vld_q, rcvr_vld_d, mis_miss_q, mis_miss_d, cmt_err_q, cmt_err_d;
  logic [POS_W-1:0] rcvr_pos_q, rcvr_pos_d;
  logic cmt_ok, hit, ins;
  assign cnt       = tail_q - head_q;
  assign count     = cnt;
  assign empty     = head_q == tail_q;
  assign full      = head_q[AW-1:0] == tail_q[AW-1:0] && head_q[AW] != tail_q[AW];
  assign head_indx = empty ? '0 : idx_q[head_q[AW-1:0]];
  assign rcvr_vld  = rcvr_vld_q;
  assign rcvr_pos  = rcvr_pos_q;
  assign mis_miss  = mis_miss_q;
  assign cmt_err   = cmt_err_q;
  always_comb begin
    p = '0;
    pc = '0;
    for (int i = 0; i < WAYS; i++) pc = pc + PW'(brch[i]);
    can_accept = pc <= PW'(DEPTH) - cnt;
    cmt_ok = cmt_brch && !empty && idx_q[head_q[AW-1:0]] == cmt_brch_indx;
    head_d = head_q + PW'(cmt_ok);
    rem = tail_q - head_d;
    hit = 1'b0;
    hit_ptr = tail_q;
    // scan youngest to oldest so the match nearest the head is the one kept
    for (int k = DEPTH - 1; k >= 0; k--) begin
      p = head_d + PW'(k);
      if (mis_pred && PW'(k) < rem && idx_q[p[AW-1:0]] == brch_mis_indx) begin
        hit = 1'b1;
        hit_ptr = p;
      end
    end
    ins = pc != '0 && can_accept && !hit;
    tail_d = hit ? hit_ptr : ins ? tail_q + pc : tail_q;
    idx_d = idx_q;
    pos_d = pos_q;
    off = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (ins && brch[i]) begin
        p = tail_q + off;
        idx_d[p[AW-1:0]] = nxt_indx + IDX_W'(i);
        pos_d[p[AW-1:0]] = pos_in[i*POS_W +: POS_W];
        off = off + 1'b1;
      end
    end
    rcvr_vld_d = hit;
    rcvr_pos_d = hit ? pos_q[hit_ptr[AW-1:0]] : rcvr_pos_q;
    mis_miss_d = mis_pred && !hit;
    cmt_err_d  = cmt_brch && !cmt_ok;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      rcvr_vld_q <= 1'b0;
      rcvr_pos_q <= '0;
      mis_miss_q <= 1'b0;
      cmt_err_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        idx_q[i] <= '0;
        pos_q[i] <= '0;
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      rcvr_vld_q <= rcvr_vld_d;
      rcvr_pos_q <= rcvr_pos_d;
      mis_miss_q <= mis_miss_d;
      cmt_err_q  <= cmt_err_d;
      idx_q      <= idx_d;
      pos_q      <= pos_d;
    end
  end
endmodule
